// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite responder in front of a word-organised SRAM of 2**MEM_AW 32-bit
//   words. It accepts pipelined transfers and inserts WAIT_STATES wait cycles
//   in every OKAY data phase. It supports byte, halfword and word accesses.
//   Misaligned transfers, and HSIZE above word, get the two-cycle ERROR
//   response and never touch the array.
//
// Ports
//   hclk       bus clock, rising edge
//   hreset     synchronous active-high reset
//   hsel       slave select from the decoder
//   haddr      byte address; bits [MEM_AW+1:2] index the array
//   htrans     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite     1 = write
//   hsize      0 byte, 1 halfword, 2 word, >2 error
//   hwdata     write data, data phase
//   hready     bus-wide ready
//   hrdata     read data, zero outside a read's final data cycle
//   hreadyout  this slave's ready
//   hresp      0 OKAY, 1 ERROR
//
// state  | meaning
// S_IDLE | no data phase in progress, ready/OKAY
// S_WAIT | OKAY data phase, wait-state down-counter running
// S_DATA | final OKAY data-phase cycle; a write commits on its closing edge
// S_ERR1 | first ERROR cycle (not ready)
// S_ERR2 | second ERROR cycle (ready)
module ahb_sram_slave #(
  parameter int MEM_AW      = 13,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW+1:0] addr_q;
  logic              write_q;
  logic [1:0]        size_q;

  logic [31:0]       mem [2**MEM_AW];

  logic              can_start;
  logic              start;
  logic              err_in;
  logic [3:0]        be;
  logic [MEM_AW-1:0] idx;
  logic              unused_bits;

  assign unused_bits = ^{haddr[31:MEM_AW+2], htrans[0]};

  // A new address phase is only taken where the bus is allowed to start one:
  // idle, or in the last (ready) cycle of a data phase or error response.
  assign can_start = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign start     = can_start && hsel && hready && htrans[1];

  assign err_in = (hsize > 3'd2) ||
                  ((hsize == 3'd1) && haddr[0]) ||
                  ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  assign idx = addr_q[MEM_AW+1:2];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        addr_q  <= haddr[MEM_AW+1:0];
        write_q <= hwrite;
        size_q  <= hsize[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (start) begin
          if (err_in) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // The array has no reset; a reset on the closing edge of S_DATA drops the write.
  always_ff @(posedge hclk) begin
    if (!hreset && (state_q == S_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  assign hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem[idx] : 32'd0;

endmodule
